// File: rtl/ddram_rom_loader.sv
// Packs the PCM region of the ROM download stream into 64-bit DDRAM words with byte
// enables and writes them one word at a time, stalling the HPS download during each write.
module ddram_rom_loader #(
  parameter logic [7:0]  INDEX        = 8'd0,
  parameter logic [24:0] REGION_START = 25'h40000,
  parameter logic [24:0] REGION_SIZE  = 25'h40000,
  parameter logic [28:0] BASE_ADDR    = 29'h0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  input  logic        DDRAM_BUSY,
  output logic [28:0] DDRAM_ADDR,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic        done
);

  typedef enum logic {S_FILL, S_FLUSH} state_t;

  state_t      state_q, state_d;
  logic        buf_vld_q, buf_vld_d;
  logic [7:0]  buf_be_q, buf_be_d;
  logic [21:0] buf_word_q, buf_word_d;
  logic [63:0] buf_data_q, buf_data_d;
  logic        pend_vld_q, pend_vld_d;
  logic [21:0] pend_word_q, pend_word_d;
  logic [2:0]  pend_lane_q, pend_lane_d;
  logic [7:0]  pend_data_q, pend_data_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic        dl_prev_q;
  logic        wait_q;

  logic [24:0] rel;
  logic [25:0] region_end;
  logic        in_region, byte_ok, dl_fall, accept, race;
  logic [21:0] byte_word, load_word;
  logic [2:0]  byte_lane, load_lane;
  logic [7:0]  load_data;

  assign rel        = ioctl_addr - REGION_START;
  assign region_end = {1'b0, REGION_START} + {1'b0, REGION_SIZE};
  assign in_region  = (ioctl_addr >= REGION_START) && ({1'b0, ioctl_addr} < region_end);
  assign byte_ok    = ioctl_download & ioctl_wr & (ioctl_index == INDEX) & in_region;
  assign byte_word  = rel[24:3];
  assign byte_lane  = rel[2:0];
  assign dl_fall    = dl_prev_q & ~ioctl_download;
  assign accept     = (state_q == S_FLUSH) & ~DDRAM_BUSY;
  // A strobe that slips in before wait is visible is kept rather than dropped.
  assign race       = (state_q == S_FLUSH) & byte_ok & ~wait_q & ~pend_vld_q;

  assign load_word  = pend_vld_q ? pend_word_q : byte_word;
  assign load_lane  = pend_vld_q ? pend_lane_q : byte_lane;
  assign load_data  = pend_vld_q ? pend_data_q : ioctl_dout;

  always_comb begin
    state_d     = state_q;
    buf_vld_d   = buf_vld_q;
    buf_be_d    = buf_be_q;
    buf_word_d  = buf_word_q;
    buf_data_d  = buf_data_q;
    pend_vld_d  = pend_vld_q;
    pend_word_d = pend_word_q;
    pend_lane_d = pend_lane_q;
    pend_data_d = pend_data_q;
    last_d      = last_q;
    done_d      = 1'b0;

    case (state_q)
      S_FILL: begin
        if (byte_ok) begin
          if (!buf_vld_q || byte_word == buf_word_q) begin
            if (!buf_vld_q) begin
              buf_data_d = '0;
              buf_be_d   = '0;
            end
            buf_data_d[byte_lane*8 +: 8] = ioctl_dout;
            buf_be_d[byte_lane]          = 1'b1;
            buf_word_d                   = byte_word;
            buf_vld_d                    = 1'b1;
            if (byte_lane == 3'd7) state_d = S_FLUSH;
          end else begin
            pend_vld_d  = 1'b1;
            pend_word_d = byte_word;
            pend_lane_d = byte_lane;
            pend_data_d = ioctl_dout;
            state_d     = S_FLUSH;
          end
        end else if (dl_fall) begin
          if (buf_vld_q) begin
            last_d  = 1'b1;
            state_d = S_FLUSH;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_FLUSH: begin
        if (dl_fall) last_d = 1'b1;
        if (accept) begin
          buf_vld_d  = 1'b0;
          buf_be_d   = '0;
          buf_data_d = '0;
          state_d    = S_FILL;
          if (pend_vld_q || race) begin
            buf_vld_d                    = 1'b1;
            buf_word_d                   = load_word;
            buf_be_d[load_lane]          = 1'b1;
            buf_data_d[load_lane*8 +: 8] = load_data;
            pend_vld_d                   = 1'b0;
            if (load_lane == 3'd7 || last_d) state_d = S_FLUSH;
          end else if (last_d) begin
            done_d = 1'b1;
            last_d = 1'b0;
          end
        end else if (race) begin
          pend_vld_d  = 1'b1;
          pend_word_d = byte_word;
          pend_lane_d = byte_lane;
          pend_data_d = ioctl_dout;
        end
      end

      default: state_d = S_FILL;
    endcase
  end

  // Control state: reset returns to an empty buffer and drops any write in flight.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_FILL;
      buf_vld_q  <= 1'b0;
      buf_be_q   <= '0;
      pend_vld_q <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      dl_prev_q  <= 1'b0;
      wait_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_vld_q  <= buf_vld_d;
      buf_be_q   <= buf_be_d;
      pend_vld_q <= pend_vld_d;
      last_q     <= last_d;
      done_q     <= done_d;
      dl_prev_q  <= ioctl_download;
      wait_q     <= (state_d == S_FLUSH);
    end
  end

  // Data payload: qualified by the valid flags above, so it needs no reset.
  always_ff @(posedge clk_sys) begin
    buf_word_q  <= buf_word_d;
    buf_data_q  <= buf_data_d;
    pend_word_q <= pend_word_d;
    pend_lane_q <= pend_lane_d;
    pend_data_q <= pend_data_d;
  end

  assign ioctl_wait     = wait_q;
  assign DDRAM_WE       = (state_q == S_FLUSH);
  assign DDRAM_ADDR     = DDRAM_WE ? BASE_ADDR + {7'd0, buf_word_q} : BASE_ADDR;
  assign DDRAM_DIN      = DDRAM_WE ? buf_data_q : 64'd0;
  assign DDRAM_BE       = DDRAM_WE ? buf_be_q : 8'd0;
  assign DDRAM_BURSTCNT = 8'd1;
  assign done           = done_q;

endmodule

// File: tb/tb_ddram_rom_loader.sv
// Directed bench for ddram_rom_loader: a word-grouping model predicts every DDRAM write,
// a per-cycle checker compares accepted writes, stall stability, wait and done.
module tb_ddram_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset, ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, ioctl_index;
  logic        ioctl_wait, DDRAM_BUSY;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE, DDRAM_BURSTCNT;
  logic        DDRAM_WE, done;

  always #5 clk_sys = ~clk_sys;

  ddram_rom_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
    .ioctl_wait(ioctl_wait), .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_ADDR(DDRAM_ADDR),
    .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE),
    .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .done(done)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [28:0] addr;
    logic [7:0]  be;
    logic [63:0] din;
  } wr_t;

  wr_t         exp_q[$];
  logic        m_vld;
  logic [21:0] m_word;
  logic [7:0]  m_be;
  logic [63:0] m_data;
  int          exp_done = 0;

  // Checker-side observations
  logic        chk_en = 1'b0;
  int          cyc = 0, wr_cnt = 0, done_cnt = 0, stall = 0, last_stall = 0;
  int          wrun = 0, last_wait_len = 0, last_acc_cyc = -10, last_done_cyc = -20;
  logic [28:0] last_addr;
  logic [63:0] last_din;
  logic [7:0]  last_be;
  logic        hold_prev = 1'b0;
  logic [28:0] prev_addr;
  logic [63:0] prev_din;
  logic [7:0]  prev_be;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] lane_mask(input logic [7:0] be);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

  task automatic model_push();
    wr_t w;
    w.addr = 29'(m_word);
    w.be   = m_be;
    w.din  = m_data;
    exp_q.push_back(w);
    m_vld  = 1'b0;
    m_be   = 8'd0;
    m_data = 64'd0;
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_vld  = 1'b0;
    m_be   = 8'd0;
    m_data = 64'd0;
  endtask

  // One strobe, issued #1 after a rising edge; the model groups bytes into words.
  task automatic send(input logic [24:0] a, input logic [7:0] d, input logic [7:0] idx);
    logic [24:0] rel;
    logic [21:0] w;
    logic [2:0]  l;
    if (ioctl_download && idx == 8'd0 && a >= 25'h40000 && a < 25'h80000) begin
      rel = a - 25'h40000;
      w   = rel[24:3];
      l   = rel[2:0];
      if (m_vld && w != m_word) model_push();
      if (!m_vld) begin
        m_vld  = 1'b1;
        m_word = w;
      end
      m_data[l*8 +: 8] = d;
      m_be[l]          = 1'b1;
      if (l == 3'd7) model_push();
    end
    ioctl_wr    = 1'b1;
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_index = idx;
    @(posedge clk_sys); #1;
    ioctl_wr    = 1'b0;
    ioctl_index = 8'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_sys); #1; end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ioctl_wait && n < 50) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check("wait_bound", 64'(ioctl_wait), 64'd0);
  endtask

  task automatic end_dl();
    if (m_vld) model_push();
    exp_done++;
    ioctl_download = 1'b0;
    idle(1);
    wait_idle();
    idle(2);
    ioctl_download = 1'b1;
    idle(1);
  endtask

  always @(negedge clk_sys) begin
    if (chk_en) begin
      cyc++;
      check("burstcnt", 64'(DDRAM_BURSTCNT), 64'd1);
      check("wait_vs_we", 64'(ioctl_wait), 64'(DDRAM_WE));
      if (ioctl_wr) check("strobe_during_wait", 64'(ioctl_wait), 64'd0);
      if (hold_prev) begin
        check("hold_we", 64'(DDRAM_WE), 64'd1);
        check("hold_addr", 64'(DDRAM_ADDR), 64'(prev_addr));
        check("hold_din", DDRAM_DIN, prev_din);
        check("hold_be", 64'(DDRAM_BE), 64'(prev_be));
      end
      if (DDRAM_WE && !DDRAM_BUSY) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %h be %h, none required", DDRAM_ADDR, DDRAM_BE);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 64'(DDRAM_ADDR), 64'(e.addr));
          check("wr_be", 64'(DDRAM_BE), 64'(e.be));
          check("wr_din", DDRAM_DIN & lane_mask(DDRAM_BE), e.din & lane_mask(e.be));
        end
        last_addr    = DDRAM_ADDR;
        last_din     = DDRAM_DIN;
        last_be      = DDRAM_BE;
        last_acc_cyc = cyc;
        last_stall   = stall;
        stall        = 0;
        wr_cnt++;
      end
      if (DDRAM_WE && DDRAM_BUSY) stall++;
      if (ioctl_wait) wrun++;
      else if (wrun > 0) begin
        last_wait_len = wrun;
        wrun = 0;
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      hold_prev = DDRAM_WE & DDRAM_BUSY & ~reset;
      prev_addr = DDRAM_ADDR;
      prev_din  = DDRAM_DIN;
      prev_be   = DDRAM_BE;
    end
  end

  initial begin
    int wr_before;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
    ioctl_dout = '0; ioctl_index = '0; DDRAM_BUSY = 1'b0;
    model_clear();
    idle(3);
    check("rst_we", 64'(DDRAM_WE), 64'd0);
    check("rst_wait", 64'(ioctl_wait), 64'd0);
    check("rst_be", 64'(DDRAM_BE), 64'd0);
    check("rst_din", DDRAM_DIN, 64'd0);
    check("rst_addr", 64'(DDRAM_ADDR), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    ioctl_download = 1'b1;
    idle(1);

    // Sequential 16 bytes: two full words
    for (int i = 0; i < 16; i++) begin
      send(25'h40000 + 25'(i), 8'(i), 8'd0);
      wait_idle();
    end
    idle(2);
    check("s1_count", 64'(wr_cnt), 64'd2);
    check("s1_addr", 64'(last_addr), 64'd1);
    check("s1_din", last_din, 64'h0F0E0D0C0B0A0908);
    check("s1_be", 64'(last_be), 64'hFF);
    check("s1_wait_len", 64'(last_wait_len), 64'd1);

    // Partial word flushed by download end
    send(25'h40008, 8'hAA, 8'd0);
    send(25'h40009, 8'hBB, 8'd0);
    send(25'h4000A, 8'hCC, 8'd0);
    end_dl();
    check("s2_addr", 64'(last_addr), 64'd1);
    check("s2_be", 64'(last_be), 64'h07);
    check("s2_din", 64'(last_din[23:0]), 64'hCCBBAA);
    check("s2_done_cnt", 64'(done_cnt), 64'd1);
    check("s2_done_timing", 64'(last_done_cyc), 64'(last_acc_cyc + 1));

    // Flush stalled by BUSY for 5 cycles
    DDRAM_BUSY = 1'b1;
    for (int i = 0; i < 8; i++) send(25'h40010 + 25'(i), 8'h10 + 8'(i), 8'd0);
    idle(5);
    DDRAM_BUSY = 1'b0;
    wait_idle();
    idle(2);
    check("s3_stall", 64'(last_stall), 64'd5);
    check("s3_wait_len", 64'(last_wait_len), 64'd6);
    check("s3_addr", 64'(last_addr), 64'd2);
    check("s3_din", last_din, 64'h1716151413121110);

    // Word change: second byte held pending then buffered
    wr_before = wr_cnt;
    send(25'h40000, 8'h11, 8'd0);
    send(25'h40020, 8'h22, 8'd0);
    wait_idle();
    idle(2);
    check("s4_first_addr", 64'(last_addr), 64'd0);
    check("s4_first_be", 64'(last_be), 64'h01);
    end_dl();
    check("s4_count", 64'(wr_cnt - wr_before), 64'd2);
    check("s4_addr", 64'(last_addr), 64'd4);
    check("s4_be", 64'(last_be), 64'h01);
    check("s4_din", 64'(last_din[7:0]), 64'h22);

    // Ignored strobes
    wr_before = wr_cnt;
    send(25'h40018, 8'h33, 8'd0);
    send(25'h3FFFF, 8'h44, 8'd0);
    check("s5_wait_lo", 64'(ioctl_wait), 64'd0);
    send(25'h80000, 8'h55, 8'd0);
    check("s5_wait_hi", 64'(ioctl_wait), 64'd0);
    send(25'h40020, 8'h66, 8'd1);
    check("s5_wait_idx", 64'(ioctl_wait), 64'd0);
    idle(2);
    check("s5_no_write", 64'(wr_cnt), 64'(wr_before));
    end_dl();
    check("s5_addr", 64'(last_addr), 64'd3);
    check("s5_be", 64'(last_be), 64'h01);
    check("s5_din", 64'(last_din[7:0]), 64'h33);

    // Reset during a stalled write
    DDRAM_BUSY = 1'b1;
    for (int i = 0; i < 8; i++) send(25'h40028 + 25'(i), 8'hA0 + 8'(i), 8'd0);
    idle(1);
    check("s6_we_before", 64'(DDRAM_WE), 64'd1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    model_clear();
    DDRAM_BUSY = 1'b0;
    check("s6_we_after", 64'(DDRAM_WE), 64'd0);
    check("s6_wait_after", 64'(ioctl_wait), 64'd0);
    idle(2);
    check("s6_done_none", 64'(done_cnt), 64'(exp_done));
    send(25'h40001, 8'h55, 8'd0);
    end_dl();
    check("s6_addr", 64'(last_addr), 64'd0);
    check("s6_be", 64'(last_be), 64'h02);
    check("s6_din", 64'(last_din[15:8]), 64'h55);

    idle(3);
    check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_total", 64'(done_cnt), 64'(exp_done));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
